// File: rtl/fir_fold_sequencer.sv
// Control sequencer for a folded FIR that shares one external MAC across every tap.
// It clears the circular sample RAM after reset, accepts one sample at a time and walks
// all taps through the RAM and coefficient ROM. It then captures the MAC result and
// holds it on a valid/ready output until the consumer takes it.
module fir_fold_sequencer #(
   parameter int unsigned TAPS    = 100,
   parameter int unsigned AW      = $clog2(TAPS),
   parameter int unsigned DW      = 16,
   parameter int unsigned ACCW    = 32,
   parameter int unsigned MAC_LAT = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic signed [DW-1:0]   in_data,
   output logic                   smp_we,
   output logic [AW-1:0]          smp_waddr,
   output logic signed [DW-1:0]   smp_wdata,
   output logic [AW-1:0]          smp_raddr,
   output logic [AW-1:0]          coef_raddr,
   output logic                   mac_clr,
   output logic                   mac_en,
   input  logic signed [ACCW-1:0] acc_in,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic signed [ACCW-1:0] out_data,
   output logic                   busy
);

   // The init counter must be able to hold TAPS itself, one past the last address.
   localparam int unsigned CW = $clog2(TAPS + 1);
   localparam int unsigned LW = (MAC_LAT > 0) ? $clog2(MAC_LAT + 1) : 1;
   localparam logic [AW-1:0] LastTap = AW'(TAPS - 1);

   typedef enum logic [2:0] {StInit, StIdle, StRun, StDrain, StHold} state_e;

   state_e                 state_q, state_d;
   logic [AW-1:0]          wr_ptr_q;
   logic [AW-1:0]          newest_q;
   logic [AW-1:0]          k_q;
   logic [CW-1:0]          init_cnt_q;
   logic                   init_we_q;
   logic [AW-1:0]          init_addr_q;
   logic [LW-1:0]          drain_cnt_q;
   logic                   mac_en_q;
   logic                   mac_clr_q;
   logic                   out_valid_q;
   logic signed [ACCW-1:0] out_data_q;
   logic [AW-1:0]          rd_addr;

   // State register; reset aborts any pass and restarts the RAM clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StInit;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StInit:  if (init_cnt_q == CW'(TAPS)) state_d = StIdle;
         StIdle:  if (in_valid) state_d = StRun;
         StRun:   if (k_q == LastTap) state_d = StDrain;
         StDrain: if (drain_cnt_q == LW'(MAC_LAT)) state_d = StHold;
         StHold:  if (out_ready) state_d = StIdle;
         default: state_d = StInit;
      endcase
   end

   // Circular read address (newest - k) mod TAPS; the wrap adds TAPS instead of dividing.
   always_comb begin
      if (newest_q >= k_q) begin
         rd_addr = newest_q - k_q;
      end else begin
         rd_addr = newest_q - k_q + AW'(TAPS);
      end
   end

   // Counters, pointers, MAC strobes and the result register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         newest_q    <= '0;
         k_q         <= '0;
         init_cnt_q  <= '0;
         init_we_q   <= 1'b0;
         init_addr_q <= '0;
         drain_cnt_q <= '0;
         mac_en_q    <= 1'b0;
         mac_clr_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         init_we_q <= 1'b0;
         // Strobes lag the address cycle by one so they line up with RAM/ROM read data.
         mac_en_q  <= (state_q == StRun);
         mac_clr_q <= (state_q == StRun) && (k_q == '0);
         unique case (state_q)
            StInit: begin
               // The clear write is registered so the write port stays quiet during reset.
               if (init_cnt_q != CW'(TAPS)) begin
                  init_we_q   <= 1'b1;
                  init_addr_q <= init_cnt_q[AW-1:0];
                  init_cnt_q  <= init_cnt_q + CW'(1);
               end
            end
            StIdle: begin
               if (in_valid) begin
                  newest_q <= wr_ptr_q;
                  wr_ptr_q <= (wr_ptr_q == LastTap) ? '0 : wr_ptr_q + AW'(1);
                  k_q      <= '0;
               end
            end
            StRun: begin
               drain_cnt_q <= '0;
               k_q         <= (k_q == LastTap) ? '0 : k_q + AW'(1);
            end
            StDrain: begin
               drain_cnt_q <= drain_cnt_q + LW'(1);
               if (drain_cnt_q == LW'(MAC_LAT)) begin
                  out_data_q  <= acc_in;
                  out_valid_q <= 1'b1;
               end
            end
            StHold: begin
               if (out_ready) out_valid_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Output decode; the sample write on accept is combinational with the handshake.
   always_comb begin
      in_ready   = 1'b0;
      busy       = 1'b1;
      smp_we     = init_we_q;
      smp_waddr  = init_addr_q;
      smp_wdata  = '0;
      smp_raddr  = '0;
      coef_raddr = '0;
      unique case (state_q)
         StIdle: begin
            in_ready  = 1'b1;
            busy      = 1'b0;
            smp_we    = in_valid;
            smp_waddr = wr_ptr_q;
            smp_wdata = in_data;
         end
         StRun: begin
            smp_raddr  = rd_addr;
            coef_raddr = k_q;
         end
         default: ;
      endcase
      mac_en    = mac_en_q;
      mac_clr   = mac_clr_q;
      out_valid = out_valid_q;
      out_data  = out_data_q;
   end

endmodule

// File: tb/tb_fir_fold_sequencer.sv
// Bench for fir_fold_sequencer: behavioural sample RAM, coefficient ROM and a two-stage
// MAC surround the sequencer. Results are compared against a direct convolution of the
// samples sent since the last reset.
module tb_fir_fold_sequencer;

   localparam int TAPS = 100;
   localparam int AW   = 7;
   localparam int LAT  = TAPS + 2 + 2;

   logic               clk       = 1'b0;
   logic               rst_n     = 1'b0;
   logic               in_valid  = 1'b0;
   logic               out_ready = 1'b1;
   logic signed [15:0] in_data   = '0;
   logic signed [31:0] acc_in    = '0;
   logic               in_ready, smp_we, mac_clr, mac_en, out_valid, busy;
   logic [AW-1:0]      smp_waddr, smp_raddr, coef_raddr;
   logic signed [15:0] smp_wdata;
   logic signed [31:0] out_data;

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc          = 0;
   int raddr_oob    = 0;
   int coef [TAPS];
   int xs[$];

   logic signed [15:0] ram [TAPS];
   logic signed [15:0] rom [TAPS];
   logic signed [15:0] ram_q = '0;
   logic signed [15:0] rom_q = '0;
   logic signed [31:0] acc1  = '0;
   logic signed [31:0] prod;
   bit                 ram_scrambled = 1'b0;

   fir_fold_sequencer #(.TAPS(TAPS)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .smp_we     (smp_we),
      .smp_waddr  (smp_waddr),
      .smp_wdata  (smp_wdata),
      .smp_raddr  (smp_raddr),
      .coef_raddr (coef_raddr),
      .mac_clr    (mac_clr),
      .mac_en     (mac_en),
      .acc_in     (acc_in),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   assign prod = int'(ram_q) * int'(rom_q);

   // Environment: RAM starts with garbage, 1-cycle reads, MAC result visible 2 cycles later.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!ram_scrambled) begin
         for (int i = 0; i < TAPS; i++) ram[i] <= 16'($urandom);
         ram_scrambled <= 1'b1;
      end else if (smp_we && int'(smp_waddr) < TAPS) begin
         ram[smp_waddr] <= smp_wdata;
      end
      ram_q <= ram[smp_raddr];
      rom_q <= rom[coef_raddr];
      if (mac_en) acc1 <= mac_clr ? prod : acc1 + prod;
      acc_in <= acc1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // y[n] = sum_k c[k] * x[n-k], history before the last reset counts as zero.
   function automatic int golden();
      int s = 0;
      int n = xs.size() - 1;
      for (int k = 0; k < TAPS; k++) begin
         if (n - k >= 0) s += coef[k] * xs[n - k];
      end
      return s;
   endfunction

   // Sends one sample and waits for its result with out_ready held high; no checking here.
   task automatic run_one(input int x, output int got, output int acc_cyc, output int wa,
                          output bit ok);
      int n;
      ok = 1'b0; got = 0; acc_cyc = 0; wa = 0;
      in_data  = 16'(x);
      in_valid = 1'b1;
      n = 0;
      while (in_ready !== 1'b1 && n < 400) begin tick(); n++; end
      if (in_ready !== 1'b1) begin in_valid = 1'b0; return; end
      acc_cyc = cyc;
      wa      = int'(smp_waddr);
      tick();
      in_valid = 1'b0;
      xs.push_back(x);
      n = 0;
      while (out_valid !== 1'b1 && n < 400) begin
         if (int'(smp_raddr) >= TAPS) raddr_oob++;
         tick();
         n++;
      end
      if (out_valid !== 1'b1) return;
      got = int'(out_data);
      ok  = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      int writes = 0;
      int bad    = 0;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) tick();
      tests_run++;
      if (smp_we !== 1'b0 || in_ready !== 1'b0 || mac_en !== 1'b0 || mac_clr !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_strobes: we=%b rdy=%b en=%b clr=%b, required all 0",
                  smp_we, in_ready, mac_en, mac_clr);
      end
      tests_run++;
      if (out_valid !== 1'b0 || out_data !== 32'sd0) begin
         tests_failed++;
         $display("FAIL reset_out: valid=%b data=%0d, required 0/0", out_valid, out_data);
      end
      tests_run++;
      if (busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_busy: got %b, required 1", busy);
      end
      tests_run++;
      if (smp_waddr !== '0 || smp_raddr !== '0 || coef_raddr !== '0) begin
         tests_failed++;
         $display("FAIL reset_addr: w=%0d r=%0d c=%0d, required 0", smp_waddr, smp_raddr,
                  coef_raddr);
      end
      rst_n = 1'b1;
      xs.delete();
      for (int i = 0; i < 300; i++) begin
         tick();
         if (in_ready === 1'b1) break;
         if (smp_we === 1'b1) begin
            if (smp_waddr !== AW'(writes) || smp_wdata !== 16'sd0) bad++;
            writes++;
         end else if (writes > 0) begin
            bad++;
         end
      end
      tests_run++;
      if (writes != TAPS) begin
         tests_failed++;
         $display("FAIL init_count: got %0d writes, required %0d", writes, TAPS);
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL init_sequence: got %0d bad cycles, required 0", bad);
      end
      tests_run++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL init_to_idle: rdy=%b busy=%b, required 1/0", in_ready, busy);
      end
   endtask

   task automatic test_impulse(input int count);
      int got, ac, wa;
      bit ok;
      out_ready = 1'b1;
      for (int n = 0; n < count; n++) begin
         run_one((n == 0) ? 1 : 0, got, ac, wa, ok);
         tests_run++;
         if (!ok || got != coef[n]) begin
            tests_failed++;
            $display("FAIL impulse[%0d]: got %0d (ok=%0b), required %0d", n, got, ok, coef[n]);
         end
      end
   endtask

   task automatic test_latency();
      int  newest = xs.size() % TAPS;
      int  x      = int'($urandom_range(0, 65535)) - 32768;
      int  first_ov = -1;
      int  got = 0, en_err = 0, clr_err = 0, addr_err = 0, n = 0;
      bit  en [111];
      bit  clr [111];
      out_ready = 1'b1;
      in_data   = 16'(x);
      in_valid  = 1'b1;
      while (in_ready !== 1'b1 && n < 400) begin tick(); n++; end
      tests_run++;
      if (in_ready !== 1'b1) begin
         tests_failed++;
         in_valid = 1'b0;
         $display("FAIL latency_accept: in_ready=%b, required 1", in_ready);
         return;
      end
      xs.push_back(x);
      for (int t = 1; t <= 110; t++) begin
         tick();
         if (t == 1) in_valid = 1'b0;
         en[t]  = (mac_en === 1'b1);
         clr[t] = (mac_clr === 1'b1);
         if (out_valid === 1'b1 && first_ov < 0) begin first_ov = t; got = int'(out_data); end
         if (t <= TAPS) begin
            if (smp_raddr !== AW'(((newest - (t - 1)) % TAPS + TAPS) % TAPS) ||
                coef_raddr !== AW'(t - 1)) addr_err++;
         end
      end
      for (int t = 1; t <= 110; t++) begin
         if (en[t] != (t >= 2 && t <= TAPS + 1)) en_err++;
         if (clr[t] != (t == 2)) clr_err++;
      end
      tests_run++;
      if (en_err != 0) begin
         tests_failed++;
         $display("FAIL latency_mac_en: got %0d wrong cycles, required 0", en_err);
      end
      tests_run++;
      if (clr_err != 0) begin
         tests_failed++;
         $display("FAIL latency_mac_clr: got %0d wrong cycles, required 0", clr_err);
      end
      tests_run++;
      if (first_ov != LAT) begin
         tests_failed++;
         $display("FAIL latency_out_valid: got cycle %0d, required %0d", first_ov, LAT);
      end
      tests_run++;
      if (addr_err != 0) begin
         tests_failed++;
         $display("FAIL latency_addresses: got %0d wrong cycles, required 0", addr_err);
      end
      tests_run++;
      if (got != golden()) begin
         tests_failed++;
         $display("FAIL latency_result: got %0d, required %0d", got, golden());
      end
      tests_run++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL latency_idle: rdy=%b valid=%b, required 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_backpressure();
      int x = int'($urandom_range(0, 65535)) - 32768;
      int n = 0, got = 0, we_err = 0, v_err = 0, d_err = 0, q_err = 0;
      out_ready = 1'b0;
      in_data   = 16'(x);
      in_valid  = 1'b1;
      while (in_ready !== 1'b1 && n < 400) begin tick(); n++; end
      if (in_ready === 1'b1) xs.push_back(x);
      tick();
      n = 0;
      while (out_valid !== 1'b1 && n < 400) begin
         if (smp_we !== 1'b0) we_err++;
         tick();
         n++;
      end
      tests_run++;
      if (out_valid !== 1'b1 || int'(out_data) != golden()) begin
         tests_failed++;
         $display("FAIL bp_result: valid=%b got %0d, required 1/%0d", out_valid, out_data,
                  golden());
      end
      got = int'(out_data);
      for (int i = 0; i < 50; i++) begin
         tick();
         if (out_valid !== 1'b1) v_err++;
         if (int'(out_data) != got) d_err++;
         if (in_ready !== 1'b0 || smp_we !== 1'b0 || mac_en !== 1'b0) q_err++;
      end
      tests_run++;
      if (we_err != 0) begin
         tests_failed++;
         $display("FAIL bp_ignored_input: got %0d writes, required 0", we_err);
      end
      tests_run++;
      if (v_err != 0 || d_err != 0) begin
         tests_failed++;
         $display("FAIL bp_hold: got %0d valid drops, %0d data changes, required 0/0", v_err,
                  d_err);
      end
      tests_run++;
      if (q_err != 0) begin
         tests_failed++;
         $display("FAIL bp_quiet: got %0d active cycles, required 0", q_err);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL bp_release: valid=%b rdy=%b, required 0/1", out_valid, in_ready);
      end
      tick();
      tests_run++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL bp_single_transfer: valid=%b busy=%b, required 0/0", out_valid, busy);
      end
   endtask

   task automatic test_wrap();
      int got, ac, wa, prev_ac = 0;
      bit ok;
      out_ready = 1'b1;
      raddr_oob = 0;
      for (int i = 0; i < 250; i++) begin
         run_one(int'($urandom_range(0, 65535)) - 32768, got, ac, wa, ok);
         tests_run++;
         if (!ok || got != golden()) begin
            tests_failed++;
            $display("FAIL wrap_result[%0d]: got %0d (ok=%0b), required %0d", i, got, ok,
                     golden());
         end
         tests_run++;
         if (wa != (xs.size() - 1) % TAPS) begin
            tests_failed++;
            $display("FAIL wrap_wr_ptr[%0d]: got %0d, required %0d", i, wa,
                     (xs.size() - 1) % TAPS);
         end
         if (i > 0) begin
            tests_run++;
            if (ac - prev_ac != LAT + 1) begin
               tests_failed++;
               $display("FAIL back_to_back[%0d]: got spacing %0d, required %0d", i,
                        ac - prev_ac, LAT + 1);
            end
         end
         prev_ac = ac;
      end
      tests_run++;
      if (raddr_oob != 0) begin
         tests_failed++;
         $display("FAIL wrap_raddr_range: got %0d out-of-range reads, required 0", raddr_oob);
      end
   endtask

   task automatic test_reset_mid_run();
      int n = 0;
      out_ready = 1'b1;
      in_data   = 16'($urandom);
      in_valid  = 1'b1;
      while (in_ready !== 1'b1 && n < 400) begin tick(); n++; end
      for (int t = 1; t <= 41; t++) begin
         tick();
         if (t == 1) in_valid = 1'b0;
      end
      tests_run++;
      if (mac_en !== 1'b1 || coef_raddr !== AW'(40)) begin
         tests_failed++;
         $display("FAIL midrun_pre: en=%b k=%0d, required 1/40", mac_en, coef_raddr);
      end
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || mac_en !== 1'b0 || mac_clr !== 1'b0) begin
         tests_failed++;
         $display("FAIL midrun_abort: valid=%b en=%b clr=%b, required 0", out_valid, mac_en,
                  mac_clr);
      end
      tests_run++;
      if (busy !== 1'b1 || in_ready !== 1'b0 || smp_we !== 1'b0) begin
         tests_failed++;
         $display("FAIL midrun_state: busy=%b rdy=%b we=%b, required 1/0/0", busy, in_ready,
                  smp_we);
      end
      test_reset();
      test_impulse(10);
   endtask

   initial begin
      for (int i = 0; i < TAPS; i++) begin
         coef[i] = int'($urandom_range(0, 4095)) - 2048;
         rom[i]  = 16'(coef[i]);
      end
      test_reset();
      test_impulse(TAPS);
      test_latency();
      test_backpressure();
      test_wrap();
      test_reset_mid_run();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, required the summary first");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fir_fold_sequencer.md
Name: fir_fold_sequencer

Overview:
- Control sequencer for a folded, time-multiplexed FIR. One external multiply-accumulate unit is shared across all taps.
- Accepts input samples on a valid/ready handshake and writes them into a circular sample RAM. It then walks every tap, driving RAM and coefficient-ROM read addresses and the MAC clear/enable strobes.
- Captures the accumulated result and presents it on a valid/ready output.
- Sits between the sample source and the downstream consumer. It replaces the fully parallel filter where area matters more than throughput.

Parameters:
- TAPS, 100, filter length; also the depth of the sample RAM and coefficient ROM.
- AW, $clog2(TAPS), address width for the RAM and ROM.
- DW, 16, input sample width (signed).
- ACCW, 32, accumulator/output width (signed).
- MAC_LAT, 2, cycles from the last mac_en until acc_in reflects that product.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input sample valid
- in_ready  out  1  sequencer can accept a sample
- in_data  in  DW  signed input sample
- smp_we  out  1  sample RAM write enable
- smp_waddr  out  AW  sample RAM write address
- smp_wdata  out  DW  sample RAM write data
- smp_raddr  out  AW  sample RAM read address (1-cycle read latency)
- coef_raddr  out  AW  coefficient ROM read address (1-cycle read latency)
- mac_clr  out  1  MAC loads the product instead of accumulating
- mac_en  out  1  MAC consumes the operands present this cycle
- acc_in  in  ACCW  signed accumulator value returned by the MAC
- out_valid  out  1  filtered result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  ACCW  signed filtered result
- busy  out  1  high in every state except IDLE

Behaviour:
- Interface decision: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values, applied while rst_n=0 and taking effect immediately:
  - state=INIT, wr_ptr=0, tap index k=0, init counter=0
  - in_ready=0, smp_we=0, all addresses 0
  - mac_en=0, mac_clr=0
  - out_valid=0, out_data=0, busy=1
- FSM states: INIT, IDLE, RUN, DRAIN, HOLD.
- INIT:
  - Writes 0 to sample RAM addresses 0..TAPS-1, one per cycle (smp_we=1, smp_wdata=0).
  - in_ready=0 throughout. After address TAPS-1 is written, go to IDLE.
- IDLE:
  - in_ready=1, busy=0.
  - On in_valid&&in_ready (combinational): smp_we=1, smp_waddr=wr_ptr, smp_wdata=in_data.
  - Latch newest=wr_ptr; wr_ptr advances with wrap TAPS-1 -> 0; k=0; go to RUN.
- RUN, TAPS cycles, k=0..TAPS-1:
  - smp_raddr = (newest - k) mod TAPS, computed by adding TAPS when the difference is negative; no division.
  - coef_raddr = k.
  - mac_en is registered 1 cycle after each address cycle, so it aligns with the RAM/ROM data.
  - mac_clr is registered with mac_en and high only for the k=0 operand.
  - After k=TAPS-1, go to DRAIN.
- DRAIN:
  - Counts MAC_LAT cycles after the final mac_en.
  - At the end, out_data <= acc_in, out_valid <= 1, go to HOLD.
- HOLD:
  - out_data is held stable while out_valid=1.
  - On out_valid&&out_ready: out_valid <= 0, go to IDLE.
- in_ready is 1 only in IDLE. No new sample is accepted while a result is pending or computing.
- Latency: accept at cycle 0 -> out_valid first high at cycle TAPS+MAC_LAT+2 (104 with defaults).
- Throughput: minimum one sample per TAPS+MAC_LAT+3 cycles when out_ready is held 1.
- Sample RAM is never written outside INIT and the IDLE accept cycle.
- mac_en is never high outside the TAPS operand cycles of a pass.
- Result arithmetic is owned by the MAC; the sequencer passes acc_in through unmodified (no truncation or saturation).
- Reset mid-operation: any state aborts immediately, and INIT reruns so the history is all zero. A partially accumulated result is discarded and never presented.
- in_valid held high in non-IDLE states is ignored; the sample is not consumed.

Test Plan:
- Reset/INIT: release rst_n -> smp_we=1 for exactly 100 consecutive cycles with smp_waddr 0..99 and data 0; in_ready=0 throughout, then 1.
- Impulse: send 1 then 99 zeros, out_ready=1; bench has behavioural RAM, ROM and a MAC_LAT=2 MAC -> output n equals coefficient n for n=0..99.
- Latency/strobes: single accept at cycle 0 -> mac_en high cycles 2..101, mac_clr only at cycle 2, out_valid rises at cycle 104.
- Backpressure: out_ready=0 for 50 cycles in HOLD -> out_data stable, out_valid=1, in_ready=0, no smp_we or mac_en; on release, one transfer, then IDLE.
- Pointer wrap: 250 random samples -> wr_ptr wraps at 99 -> 0 twice; every output matches a golden 100-tap convolution; smp_raddr always in 0..99.
- Reset mid-RUN: drop rst_n at k=40 -> out_valid=0 and mac_en=0 at once; INIT repeats; next impulse response matches the coefficients with no stale history.
